// File: rtl/serial_deser_pkg.sv
// Shared types and default constants for the serial deserializer.
package serial_deser_pkg;

    typedef enum logic {
        HUNT     = 1'b0,
        ASSEMBLE = 1'b1
    } deser_state_t;

    localparam int unsigned DEF_WIDTH       = 8;
    localparam logic [7:0]  DEF_SYNC_WORD   = 8'hA5;
    localparam int unsigned DEF_FRAME_BYTES = 4;

endpackage

// File: rtl/serial_deser_if.sv
// Serial input, bit qualifiers and valid/ready byte output of the deserializer.
interface serial_deser_if #(
    parameter int unsigned WIDTH = 8
);
    logic             SER_IN;
    logic             BIT_EN;
    logic             DIR;
    logic [WIDTH-1:0] DATA_OUT;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             IN_FRAME;
    logic             OVERFLOW;

    modport master (
        output SER_IN, BIT_EN, DIR, OUT_READY,
        input  DATA_OUT, OUT_VALID, IN_FRAME, OVERFLOW
    );

    modport slave (
        input  SER_IN, BIT_EN, DIR, OUT_READY,
        output DATA_OUT, OUT_VALID, IN_FRAME, OVERFLOW
    );
endinterface

// File: rtl/serial_deser_window.sv
// Bit window shift register: DIR=0 shifts left (new bit at LSB), DIR=1 shifts right (new bit at MSB).
module deser_window #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             BIT_EN,
    input  logic             DIR,
    input  logic             SER_IN,
    output logic [WIDTH-1:0] window
);

    // CLR wins over a simultaneous shift so a finished frame leaves no residue
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            window <= '0;
        end else if (CLR) begin
            window <= '0;
        end else if (BIT_EN) begin
            window <= DIR ? {SER_IN, window[WIDTH-1:1]} : {window[WIDTH-2:0], SER_IN};
        end
    end

endmodule

// File: rtl/serial_deser.sv
// Sync-word framed serial-to-parallel converter with a one-entry valid/ready output stage.
module serial_deser
    import serial_deser_pkg::*;
#(
    parameter int unsigned      WIDTH       = DEF_WIDTH,
    parameter logic [WIDTH-1:0] SYNC_WORD   = WIDTH'(DEF_SYNC_WORD),
    parameter int unsigned      FRAME_BYTES = DEF_FRAME_BYTES
) (
    input  logic         CLK,
    input  logic         RST,
    serial_deser_if.slave bus
);

    localparam int unsigned BIT_CW  = $clog2(WIDTH + 1);
    localparam int unsigned BYTE_CW = $clog2(FRAME_BYTES + 1);

    deser_state_t      state, state_nxt;
    logic [BIT_CW-1:0] bit_cnt, bit_cnt_nxt;
    logic [BYTE_CW-1:0] byte_cnt, byte_cnt_nxt;
    logic              dir_lat, dir_lat_nxt;
    logic              shift_dir;
    logic              win_clr;
    logic              byte_done;
    logic [WIDTH-1:0]  window;
    logic [WIDTH-1:0]  win_post;
    logic [WIDTH-1:0]  data_q;
    logic              valid_q;
    logic              ovf_q;

    // DIR is live while hunting and frozen for the duration of a frame
    assign shift_dir = (state == HUNT) ? bus.DIR : dir_lat;
    assign win_post  = shift_dir ? {bus.SER_IN, window[WIDTH-1:1]}
                                 : {window[WIDTH-2:0], bus.SER_IN};

    deser_window #(
        .WIDTH(WIDTH)
    ) u_window (
        .CLK    (CLK),
        .RST    (RST),
        .CLR    (win_clr),
        .BIT_EN (bus.BIT_EN),
        .DIR    (shift_dir),
        .SER_IN (bus.SER_IN),
        .window (window)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state    <= HUNT;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            dir_lat  <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            byte_cnt <= byte_cnt_nxt;
            dir_lat  <= dir_lat_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        byte_cnt_nxt = byte_cnt;
        dir_lat_nxt  = dir_lat;
        win_clr      = 1'b0;
        byte_done    = 1'b0;
        case (state)
            HUNT: begin
                if (bus.BIT_EN && (win_post == SYNC_WORD)) begin
                    state_nxt    = ASSEMBLE;
                    bit_cnt_nxt  = '0;
                    byte_cnt_nxt = '0;
                    dir_lat_nxt  = bus.DIR;
                end
            end
            ASSEMBLE: begin
                if (bus.BIT_EN) begin
                    if (bit_cnt == BIT_CW'(WIDTH - 1)) begin
                        byte_done   = 1'b1;
                        bit_cnt_nxt = '0;
                        if (byte_cnt == BYTE_CW'(FRAME_BYTES - 1)) begin
                            state_nxt    = HUNT;
                            byte_cnt_nxt = '0;
                            win_clr      = 1'b1;
                        end else begin
                            byte_cnt_nxt = byte_cnt + 1'b1;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    // A byte completing into a stalled output slot is dropped and flagged
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (byte_done) begin
            if (!valid_q || bus.OUT_READY) begin
                data_q  <= win_post;
                valid_q <= 1'b1;
            end else begin
                ovf_q <= 1'b1;
            end
        end else if (valid_q && bus.OUT_READY) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.DATA_OUT  = data_q;
    assign bus.OUT_VALID = valid_q;
    assign bus.IN_FRAME  = (state == ASSEMBLE);
    assign bus.OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_serial_deser.sv
// Self-checking bench for serial_deser: directed scenarios plus a randomized stream against a bit-queue model.
module tb_serial_deser;

    localparam int unsigned W  = 8;
    localparam int unsigned FB = 4;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    serial_deser_if #(.WIDTH(W)) bus ();

    serial_deser #(
        .WIDTH       (W),
        .SYNC_WORD   (SYNC),
        .FRAME_BYTES (FB)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bit history for sync search, payload bit queue per byte
    bit         hist[$];
    bit         pay[$];
    bit         m_in_frame;
    bit         m_dir;
    bit         m_valid;
    bit         m_ovf;
    logic [7:0] m_data;
    int         m_nbytes;
    logic [7:0] seen[$];

    function automatic logic [7:0] pack_bits(input bit q[$], input bit lsb_first);
        logic [7:0] v;
        int n;
        v = '0;
        n = q.size();
        for (int i = 0; i < n; i++)
            if (q[i]) v[lsb_first ? i : n - 1 - i] = 1'b1;
        return v;
    endfunction

    task automatic clear_hist();
        hist.delete();
        for (int i = 0; i < W; i++) hist.push_back(1'b0);
    endtask

    task automatic model_clear();
        clear_hist();
        pay.delete();
        m_in_frame = 1'b0;
        m_dir      = 1'b0;
        m_valid    = 1'b0;
        m_ovf      = 1'b0;
        m_data     = '0;
        m_nbytes   = 0;
    endtask

    // One clock: apply inputs, advance model on the edge, settle 1 time unit
    task automatic drive(input bit en, input bit b, input bit d, input bit rdy);
        bit done;
        logic [7:0] nb;
        bus.BIT_EN    = en;
        bus.SER_IN    = b;
        bus.DIR       = d;
        bus.OUT_READY = rdy;
        @(posedge CLK);
        done = 1'b0;
        nb   = '0;
        if (en) begin
            hist.push_back(b);
            void'(hist.pop_front());
            if (!m_in_frame) begin
                if (pack_bits(hist, d) == SYNC) begin
                    m_in_frame = 1'b1;
                    m_dir      = d;
                    m_nbytes   = 0;
                    pay.delete();
                end
            end else begin
                pay.push_back(b);
                if (pay.size() == W) begin
                    nb   = pack_bits(pay, m_dir);
                    done = 1'b1;
                    pay.delete();
                    m_nbytes++;
                    if (m_nbytes == FB) begin
                        m_in_frame = 1'b0;
                        clear_hist();
                    end
                end
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_data  = nb;
                m_valid = 1'b1;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        #1;
        if (bus.OUT_VALID === 1'b1) seen.push_back(bus.DATA_OUT);
    endtask

    task automatic send_bits(input logic [7:0] v, input int n, input bit d, input bit rdy,
                             input int unsigned gap_max);
        for (int i = 0; i < n; i++) begin
            int unsigned g;
            g = $urandom_range(0, gap_max);
            for (int unsigned k = 0; k < g; k++) drive(1'b0, 1'b0, d, rdy);
            drive(1'b1, d ? v[i] : v[7 - i], d, rdy);
        end
    endtask

    task automatic do_reset();
        bus.BIT_EN    = 1'b0;
        bus.SER_IN    = 1'b0;
        bus.DIR       = 1'b0;
        bus.OUT_READY = 1'b0;
        #2 RST = 1'b0;
        model_clear();
        @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    task automatic test_reset();
        bus.BIT_EN    = 1'b0;
        bus.SER_IN    = 1'b0;
        bus.DIR       = 1'b0;
        bus.OUT_READY = 1'b0;
        #1 RST = 1'b0;
        #2;
        n_cmp++; if (bus.DATA_OUT !== 8'h00) begin n_err++; $display("FAIL reset_data: got %h want 00", bus.DATA_OUT); end
        n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.OUT_VALID); end
        n_cmp++; if (bus.IN_FRAME !== 1'b0) begin n_err++; $display("FAIL reset_in_frame: got %b want 0", bus.IN_FRAME); end
        n_cmp++; if (bus.OVERFLOW !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %b want 0", bus.OVERFLOW); end
        model_clear();
        @(posedge CLK);
        #1 RST = 1'b1;
    endtask

    task automatic test_msb_frame();
        do_reset();
        send_bits(SYNC, 8, 1'b0, 1'b1, 0);
        n_cmp++; if (bus.IN_FRAME !== 1'b1) begin n_err++; $display("FAIL msb_in_frame: got %b want 1", bus.IN_FRAME); end
        send_bits(8'h3C, 7, 1'b0, 1'b1, 0);
        n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL msb_early_valid: got %b want 0", bus.OUT_VALID); end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (bus.DATA_OUT !== 8'h3C) begin n_err++; $display("FAIL msb_data: got %h want 3c", bus.DATA_OUT); end
        n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_err++; $display("FAIL msb_valid: got %b want 1", bus.OUT_VALID); end
    endtask

    task automatic test_lsb_frame();
        do_reset();
        send_bits(SYNC, 8, 1'b1, 1'b1, 0);
        n_cmp++; if (bus.IN_FRAME !== 1'b1) begin n_err++; $display("FAIL lsb_in_frame: got %b want 1", bus.IN_FRAME); end
        send_bits(8'h81, 8, 1'b1, 1'b1, 0);
        n_cmp++; if (bus.DATA_OUT !== 8'h81) begin n_err++; $display("FAIL lsb_data: got %h want 81", bus.DATA_OUT); end
        n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_err++; $display("FAIL lsb_valid: got %b want 1", bus.OUT_VALID); end
    endtask

    task automatic test_overlap();
        bit pattern[12];
        pattern = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, pattern[i], 1'b0, 1'b1);
            n_cmp++;
            if (bus.IN_FRAME !== ((i == 11) ? 1'b1 : 1'b0)) begin
                n_err++;
                $display("FAIL overlap_in_frame[%0d]: got %b want %b", i, bus.IN_FRAME, (i == 11));
            end
        end
        send_bits(8'h00, 7, 1'b0, 1'b1, 0);
        n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL overlap_extra_byte: got %b want 0", bus.OUT_VALID); end
    endtask

    task automatic test_overflow();
        do_reset();
        send_bits(SYNC, 8, 1'b0, 1'b0, 0);
        send_bits(8'h11, 8, 1'b0, 1'b0, 0);
        n_cmp++; if (bus.DATA_OUT !== 8'h11) begin n_err++; $display("FAIL ovf_first_data: got %h want 11", bus.DATA_OUT); end
        n_cmp++; if (bus.OVERFLOW !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", bus.OVERFLOW); end
        send_bits(8'h22, 8, 1'b0, 1'b0, 0);
        n_cmp++; if (bus.DATA_OUT !== 8'h11) begin n_err++; $display("FAIL ovf_held_data: got %h want 11", bus.DATA_OUT); end
        n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_err++; $display("FAIL ovf_held_valid: got %b want 1", bus.OUT_VALID); end
        n_cmp++; if (bus.OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", bus.OVERFLOW); end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL ovf_drain_valid: got %b want 0", bus.OUT_VALID); end
        n_cmp++; if (bus.OVERFLOW !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", bus.OVERFLOW); end
    endtask

    task automatic test_gaps();
        bit d;
        d = 1'($urandom_range(0, 1));
        do_reset();
        send_bits(SYNC, 8, d, 1'b1, 3);
        seen.delete();
        for (int b = 1; b <= 4; b++) send_bits(8'(b), 8, d, 1'b1, 3);
        drive(1'b0, 1'b0, d, 1'b1);
        n_cmp++; if (seen.size() != 4) begin n_err++; $display("FAIL gaps_count: got %0d want 4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            n_cmp++;
            if (seen[i] !== 8'(i + 1)) begin n_err++; $display("FAIL gaps_byte[%0d]: got %h want %h", i, seen[i], 8'(i + 1)); end
        end
        n_cmp++; if (bus.IN_FRAME !== 1'b0) begin n_err++; $display("FAIL gaps_frame_end: got %b want 0", bus.IN_FRAME); end
        send_bits(SYNC, 8, d, 1'b1, 3);
        n_cmp++; if (bus.IN_FRAME !== 1'b1) begin n_err++; $display("FAIL gaps_resync: got %b want 1", bus.IN_FRAME); end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        send_bits(SYNC, 8, 1'b0, 1'b1, 0);
        send_bits(8'hFF, 3, 1'b0, 1'b1, 0);
        #2 RST = 1'b0;
        #1;
        n_cmp++; if (bus.IN_FRAME !== 1'b0) begin n_err++; $display("FAIL rst_mid_in_frame: got %b want 0", bus.IN_FRAME); end
        n_cmp++; if (bus.OUT_VALID !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", bus.OUT_VALID); end
        n_cmp++; if (bus.DATA_OUT !== 8'h00) begin n_err++; $display("FAIL rst_mid_data: got %h want 00", bus.DATA_OUT); end
        n_cmp++; if (bus.OVERFLOW !== 1'b0) begin n_err++; $display("FAIL rst_mid_overflow: got %b want 0", bus.OVERFLOW); end
        model_clear();
        @(posedge CLK);
        #1 RST = 1'b1;
        send_bits(SYNC, 8, 1'b0, 1'b1, 0);
        send_bits(8'h5A, 8, 1'b0, 1'b1, 0);
        n_cmp++; if (bus.DATA_OUT !== 8'h5A) begin n_err++; $display("FAIL rst_mid_recover: got %h want 5a", bus.DATA_OUT); end
        n_cmp++; if (bus.OUT_VALID !== 1'b1) begin n_err++; $display("FAIL rst_mid_recover_valid: got %b want 1", bus.OUT_VALID); end
    endtask

    task automatic test_random();
        bit stream[$];
        bit hd, en, b, d, rdy;
        logic [7:0] v;
        hd = 1'($urandom_range(0, 1));
        do_reset();
        for (int f = 0; f < 12; f++) begin
            int unsigned noise;
            noise = $urandom_range(0, 10);
            for (int unsigned k = 0; k < noise; k++) stream.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i < 8; i++) stream.push_back(hd ? SYNC[i] : SYNC[7 - i]);
            for (int n = 0; n < FB * 8; n++) stream.push_back(1'($urandom_range(0, 1)));
        end
        while (stream.size() > 0) begin
            en  = ($urandom_range(0, 9) < 7);
            b   = en ? stream[0] : 1'($urandom_range(0, 1));
            if (en) void'(stream.pop_front());
            d   = m_in_frame ? 1'($urandom_range(0, 1)) : hd;
            rdy = ($urandom_range(0, 2) != 0);
            drive(en, b, d, rdy);
            n_cmp++; if (bus.DATA_OUT !== m_data) begin n_err++; $display("FAIL rnd_data @%0t: got %h want %h", $time, bus.DATA_OUT, m_data); end
            n_cmp++; if (bus.OUT_VALID !== m_valid) begin n_err++; $display("FAIL rnd_valid @%0t: got %b want %b", $time, bus.OUT_VALID, m_valid); end
            n_cmp++; if (bus.IN_FRAME !== m_in_frame) begin n_err++; $display("FAIL rnd_in_frame @%0t: got %b want %b", $time, bus.IN_FRAME, m_in_frame); end
            n_cmp++; if (bus.OVERFLOW !== m_ovf) begin n_err++; $display("FAIL rnd_overflow @%0t: got %b want %b", $time, bus.OVERFLOW, m_ovf); end
        end
        v = m_data;
        drive(1'b0, 1'b0, hd, 1'b0);
        n_cmp++; if (bus.DATA_OUT !== v) begin n_err++; $display("FAIL rnd_idle_hold: got %h want %h", bus.DATA_OUT, v); end
    endtask

    initial begin
        test_reset();
        test_msb_frame();
        test_lsb_frame();
        test_overlap();
        test_overflow();
        test_gaps();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
